tl_periph_socket: RTL and testbench

TL_PERIPH_SOCKET -- requirements
Module: tl_periph_socket

---
 rtl/tl_periph_pkg.sv | 25 ++
 rtl/tl_rr_arbiter.sv | 60 ++++++
 rtl/tl_periph_socket.sv | 183 ++++++++++++++++++
 tb/tb_tl_periph_socket.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_periph_pkg.sv
// Shared TL-UL opcodes, size field width and the default peripheral address map.
package tl_periph_pkg;

    localparam int unsigned MaxDev = 8;
    localparam int unsigned SizeW  = 3;
    localparam int unsigned OpW    = 3;

    typedef enum logic [OpW-1:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [OpW-1:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    // Four 4 KiB windows at 0x0000_0000, 0x1000_0000, 0x2000_0000, 0x3000_0000.
    localparam logic [3:0][31:0] DefaultDevBase = {
        32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };
    localparam logic [3:0][31:0] DefaultDevMask = {4{32'h0000_0FFF}};

endpackage

// File: rtl/tl_rr_arbiter.sv
// Round-robin arbiter whose grant is held until the granted beat is accepted (advance).
module tl_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] hold_idx_q;
    logic            hold_q;
    logic [IdxW-1:0] pick_idx;
    logic            pick_vld;
    logic [IdxW-1:0] gnt_idx;
    int unsigned     scan_idx;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        pick_idx = ptr_q;
        pick_vld = 1'b0;
        scan_idx = 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = (32'(ptr_q) + k) % N;
            if (!pick_vld && req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = IdxW'(scan_idx);
            end
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_idx = pick_idx;
        if (hold_q) begin
            gnt_idx          = hold_idx_q;
            gnt[hold_idx_q]  = req[hold_idx_q];
        end else if (pick_vld) begin
            gnt[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            hold_q     <= (|gnt) && !advance;
            hold_idx_q <= gnt_idx;
            if (advance && (|gnt)) begin
                ptr_q <= (gnt_idx == IdxW'(N - 1)) ? '0 : IdxW'(gnt_idx + 1'b1);
            end
        end
    end

endmodule

// File: rtl/tl_periph_socket.sv
// 1:N TL-UL peripheral socket: address decode, per-device in-flight limits,
// a one-entry error responder for unmapped/oversized requests, and RR D-channel return.
module tl_periph_socket
    import tl_periph_pkg::*;
#(
    parameter int unsigned NumDev         = 4,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned SourceWidth    = 1,
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [NumDev-1:0][AddrWidth-1:0] DevBase = DefaultDevBase,
    parameter logic [NumDev-1:0][AddrWidth-1:0] DevMask = DefaultDevMask,
    localparam int unsigned MaskW = DataWidth / 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   host_a_valid,
    input  logic [OpW-1:0]                         host_a_opcode,
    input  logic [SizeW-1:0]                       host_a_size,
    input  logic [SourceWidth-1:0]                 host_a_source,
    input  logic [AddrWidth-1:0]                   host_a_address,
    input  logic [MaskW-1:0]                       host_a_mask,
    input  logic [DataWidth-1:0]                   host_a_data,
    output logic                                   host_a_ready,
    output logic                                   host_d_valid,
    output logic [OpW-1:0]                         host_d_opcode,
    output logic [SizeW-1:0]                       host_d_size,
    output logic [SourceWidth-1:0]                 host_d_source,
    output logic                                   host_d_denied,
    output logic                                   host_d_corrupt,
    output logic [DataWidth-1:0]                   host_d_data,
    input  logic                                   host_d_ready,
    output logic [NumDev-1:0]                      dev_a_valid,
    output logic [NumDev-1:0][OpW-1:0]             dev_a_opcode,
    output logic [NumDev-1:0][SizeW-1:0]           dev_a_size,
    output logic [NumDev-1:0][SourceWidth-1:0]     dev_a_source,
    output logic [NumDev-1:0][AddrWidth-1:0]       dev_a_address,
    output logic [NumDev-1:0][MaskW-1:0]           dev_a_mask,
    output logic [NumDev-1:0][DataWidth-1:0]       dev_a_data,
    input  logic [NumDev-1:0]                      dev_a_ready,
    input  logic [NumDev-1:0]                      dev_d_valid,
    input  logic [NumDev-1:0][OpW-1:0]             dev_d_opcode,
    input  logic [NumDev-1:0][SizeW-1:0]           dev_d_size,
    input  logic [NumDev-1:0][SourceWidth-1:0]     dev_d_source,
    input  logic [NumDev-1:0]                      dev_d_denied,
    input  logic [NumDev-1:0]                      dev_d_corrupt,
    input  logic [NumDev-1:0][DataWidth-1:0]       dev_d_data,
    output logic [NumDev-1:0]                      dev_d_ready,
    output logic                                   idle_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned ArbN = NumDev + 1;

    logic [NumDev-1:0][CntW-1:0] cnt_q;
    logic [NumDev-1:0]           cnt_ok;
    logic [NumDev-1:0]           sel_oh;
    logic                        hit;
    logic                        size_ok;
    logic [NumDev-1:0]           a_fire;
    logic [NumDev-1:0]           d_fire;
    logic [ArbN-1:0]             arb_req;
    logic [ArbN-1:0]             arb_gnt;
    logic                        d_fire_host;
    logic                        err_load;
    logic                        err_done;
    logic                        err_vld_q;
    logic                        err_get_q;
    logic [SizeW-1:0]            err_size_q;
    logic [SourceWidth-1:0]      err_source_q;
    logic                        cnt_busy;

    assign size_ok = host_a_size <= SizeW'($clog2(MaskW));

    // Lowest matching index wins; oversized transfers never match.
    always_comb begin
        sel_oh = '0;
        hit    = 1'b0;
        for (int unsigned i = 0; i < NumDev; i++) begin
            if (!hit && size_ok && ((host_a_address & ~DevMask[i]) == DevBase[i])) begin
                sel_oh[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumDev; i++) begin
            cnt_ok[i]        = cnt_q[i] < CntW'(MaxOutstanding);
            dev_a_opcode[i]  = host_a_opcode;
            dev_a_size[i]    = host_a_size;
            dev_a_source[i]  = host_a_source;
            dev_a_address[i] = host_a_address;
            dev_a_mask[i]    = host_a_mask;
            dev_a_data[i]    = host_a_data;
        end
    end

    assign dev_a_valid  = (host_a_valid && !rst_i) ? (sel_oh & cnt_ok) : '0;
    assign host_a_ready = hit ? |(sel_oh & cnt_ok & dev_a_ready) : !err_vld_q;
    assign a_fire       = dev_a_valid & dev_a_ready;
    assign d_fire       = dev_d_valid & dev_d_ready;
    assign err_load     = host_a_valid && !hit && !err_vld_q && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NumDev; i++) begin
                case ({a_fire[i], d_fire[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
                    2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
        end
    end

    // Error responder: single entry, freed when its response is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_vld_q    <= 1'b0;
            err_get_q    <= 1'b0;
            err_size_q   <= '0;
            err_source_q <= '0;
        end else if (err_load) begin
            err_vld_q    <= 1'b1;
            err_get_q    <= host_a_opcode == OpW'(Get);
            err_size_q   <= host_a_size;
            err_source_q <= host_a_source;
        end else if (err_done) begin
            err_vld_q <= 1'b0;
        end
    end

    assign arb_req     = {err_vld_q, dev_d_valid};
    assign d_fire_host = host_d_valid && host_d_ready;
    assign err_done    = arb_gnt[NumDev] && d_fire_host;
    assign dev_d_ready = rst_i ? '0 : (arb_gnt[NumDev-1:0] & {NumDev{host_d_ready}});

    tl_rr_arbiter #(.N(ArbN)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (arb_req),
        .advance (d_fire_host),
        .gnt     (arb_gnt)
    );

    // D mux: the error responder is the default, a granted device overrides it.
    always_comb begin
        host_d_valid   = arb_gnt[NumDev];
        host_d_opcode  = err_get_q ? OpW'(AccessAckData) : OpW'(AccessAck);
        host_d_size    = err_size_q;
        host_d_source  = err_source_q;
        host_d_denied  = 1'b1;
        host_d_corrupt = err_get_q;
        host_d_data    = '0;
        for (int unsigned i = 0; i < NumDev; i++) begin
            if (arb_gnt[i]) begin
                host_d_valid   = 1'b1;
                host_d_opcode  = dev_d_opcode[i];
                host_d_size    = dev_d_size[i];
                host_d_source  = dev_d_source[i];
                host_d_denied  = dev_d_denied[i];
                host_d_corrupt = dev_d_corrupt[i];
                host_d_data    = dev_d_data[i];
            end
        end
        if (rst_i) begin
            host_d_valid = 1'b0;
        end
    end

    always_comb begin
        cnt_busy = 1'b0;
        for (int unsigned i = 0; i < NumDev; i++) begin
            cnt_busy = cnt_busy || (cnt_q[i] != '0);
        end
    end

    assign idle_o = !cnt_busy && !err_vld_q;

endmodule

// File: tb/tb_tl_periph_socket.sv
// Directed bench for tl_periph_socket; D responses are checked against a queue of expectations.
module tb_tl_periph_socket;
    import tl_periph_pkg::*;

    localparam int unsigned ND = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 host_a_valid;
    logic [2:0]           host_a_opcode;
    logic [2:0]           host_a_size;
    logic [0:0]           host_a_source;
    logic [31:0]          host_a_address;
    logic [3:0]           host_a_mask;
    logic [31:0]          host_a_data;
    logic                 host_a_ready;
    logic                 host_d_valid;
    logic [2:0]           host_d_opcode;
    logic [2:0]           host_d_size;
    logic [0:0]           host_d_source;
    logic                 host_d_denied;
    logic                 host_d_corrupt;
    logic [31:0]          host_d_data;
    logic                 host_d_ready;
    logic [ND-1:0]        dev_a_valid;
    logic [ND-1:0][2:0]   dev_a_opcode;
    logic [ND-1:0][2:0]   dev_a_size;
    logic [ND-1:0][0:0]   dev_a_source;
    logic [ND-1:0][31:0]  dev_a_address;
    logic [ND-1:0][3:0]   dev_a_mask;
    logic [ND-1:0][31:0]  dev_a_data;
    logic [ND-1:0]        dev_a_ready;
    logic [ND-1:0]        dev_d_valid;
    logic [ND-1:0][2:0]   dev_d_opcode;
    logic [ND-1:0][2:0]   dev_d_size;
    logic [ND-1:0][0:0]   dev_d_source;
    logic [ND-1:0]        dev_d_denied;
    logic [ND-1:0]        dev_d_corrupt;
    logic [ND-1:0][31:0]  dev_d_data;
    logic [ND-1:0]        dev_d_ready;
    logic                 idle_o;

    int checks = 0;
    int errors = 0;
    logic [40:0] sb[$];

    always #5 clk_i = ~clk_i;

    tl_periph_socket dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_a_valid(host_a_valid), .host_a_opcode(host_a_opcode), .host_a_size(host_a_size),
        .host_a_source(host_a_source), .host_a_address(host_a_address), .host_a_mask(host_a_mask),
        .host_a_data(host_a_data), .host_a_ready(host_a_ready),
        .host_d_valid(host_d_valid), .host_d_opcode(host_d_opcode), .host_d_size(host_d_size),
        .host_d_source(host_d_source), .host_d_denied(host_d_denied), .host_d_corrupt(host_d_corrupt),
        .host_d_data(host_d_data), .host_d_ready(host_d_ready),
        .dev_a_valid(dev_a_valid), .dev_a_opcode(dev_a_opcode), .dev_a_size(dev_a_size),
        .dev_a_source(dev_a_source), .dev_a_address(dev_a_address), .dev_a_mask(dev_a_mask),
        .dev_a_data(dev_a_data), .dev_a_ready(dev_a_ready),
        .dev_d_valid(dev_d_valid), .dev_d_opcode(dev_d_opcode), .dev_d_size(dev_d_size),
        .dev_d_source(dev_d_source), .dev_d_denied(dev_d_denied), .dev_d_corrupt(dev_d_corrupt),
        .dev_d_data(dev_d_data), .dev_d_ready(dev_d_ready),
        .idle_o(idle_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] d_beat(input logic [2:0] op, input logic [2:0] size,
                                           input logic src, input logic den, input logic cor,
                                           input logic [31:0] data);
        return {op, size, src, den, cor, data};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [31:0] addr,
                           input logic [2:0] size, input logic src);
        host_a_valid   = 1'b1;
        host_a_opcode  = op;
        host_a_address = addr;
        host_a_size    = size;
        host_a_source  = src;
        host_a_mask    = 4'hF;
        host_a_data    = addr ^ 32'h5A5A_5A5A;
    endtask

    task automatic dev_resp(input int i, input logic [2:0] op, input logic [2:0] size,
                            input logic src, input logic [31:0] data);
        dev_d_valid[i]   = 1'b1;
        dev_d_opcode[i]  = op;
        dev_d_size[i]    = size;
        dev_d_source[i]  = src;
        dev_d_denied[i]  = 1'b0;
        dev_d_corrupt[i] = 1'b0;
        dev_d_data[i]    = data;
    endtask

    // Scoreboard: every accepted host D beat must match the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && host_d_valid && host_d_ready) begin
            if (sb.size() == 0) begin
                check("d_unexpected_beat", 64'd1, 64'd0);
            end else begin
                check("d_payload", 64'({host_d_opcode, host_d_size, host_d_source,
                                        host_d_denied, host_d_corrupt, host_d_data}),
                      64'(sb.pop_front()));
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        host_a_valid = 1'b0; host_a_opcode = '0; host_a_size = '0; host_a_source = '0;
        host_a_address = '0; host_a_mask = '0; host_a_data = '0;
        host_d_ready = 1'b1;
        dev_a_ready = '1;
        dev_d_valid = '0; dev_d_opcode = '0; dev_d_size = '0; dev_d_source = '0;
        dev_d_denied = '0; dev_d_corrupt = '0; dev_d_data = '0;
        #1;
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_host_d_valid", 64'(host_d_valid), 64'd0);
        check("rst_dev_a_valid", 64'(dev_a_valid), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Get to dev1 is forwarded the same cycle and its response returns unchanged.
        drive_a(Get, 32'h1000_0004, 3'd2, 1'b1);
        #1;
        check("get_dev1_valid", 64'(dev_a_valid), 64'b0010);
        check("get_dev1_ready", 64'(host_a_ready), 64'd1);
        check("get_dev1_addr", 64'(dev_a_address[1]), 64'h1000_0004);
        tick();
        host_a_valid = 1'b0;
        #1;
        check("get_dev1_busy", 64'(idle_o), 64'd0);
        dev_resp(1, AccessAckData, 3'd2, 1'b1, 32'hCAFE_F00D);
        sb.push_back(d_beat(AccessAckData, 3'd2, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D));
        #1;
        check("get_dev1_dready", 64'(dev_d_ready), 64'b0010);
        tick();
        dev_d_valid = '0;
        #1;
        check("get_dev1_idle", 64'(idle_o), 64'd1);

        // Unmapped Put -> denied AccessAck; a second unmapped request waits for the first.
        host_d_ready = 1'b0;
        drive_a(PutFullData, 32'hDEAD_0000, 3'd2, 1'b0);
        #1;
        check("err_accept", 64'(host_a_ready), 64'd1);
        check("err_no_dev", 64'(dev_a_valid), 64'd0);
        sb.push_back(d_beat(AccessAck, 3'd2, 1'b0, 1'b1, 1'b0, 32'd0));
        tick();
        drive_a(Get, 32'hDEAD_0010, 3'd1, 1'b1);
        #1;
        check("err_rsp_next_cycle", 64'(host_d_valid), 64'd1);
        check("err_full_stall", 64'(host_a_ready), 64'd0);
        tick();
        check("err_full_stall2", 64'(host_a_ready), 64'd0);
        host_d_ready = 1'b1;
        #1;
        check("err_full_stall3", 64'(host_a_ready), 64'd0);
        tick();
        check("err_reopen", 64'(host_a_ready), 64'd1);
        sb.push_back(d_beat(AccessAckData, 3'd1, 1'b1, 1'b1, 1'b1, 32'd0));
        tick();
        host_a_valid = 1'b0;
        tick();
        check("err_idle", 64'(idle_o), 64'd1);

        // In-flight limit on dev0.
        for (int k = 0; k < 4; k++) begin
            drive_a(Get, 32'h0000_0010, 3'd2, 1'(k));
            #1;
            check("limit_accept", 64'(host_a_ready), 64'd1);
            tick();
        end
        #1;
        check("limit_stall", 64'(host_a_ready), 64'd0);
        check("limit_no_fwd", 64'(dev_a_valid), 64'd0);
        dev_resp(0, AccessAckData, 3'd2, 1'b0, 32'h0000_0100);
        sb.push_back(d_beat(AccessAckData, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0100));
        #1;
        check("limit_stall_same_cycle", 64'(host_a_ready), 64'd0);
        tick();
        dev_d_valid = '0;
        #1;
        check("limit_reopen", 64'(host_a_ready), 64'd1);
        check("limit_reopen_fwd", 64'(dev_a_valid), 64'b0001);
        tick();
        host_a_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dev_resp(0, AccessAckData, 3'd2, 1'(k), 32'h0000_0200 + 32'(k));
            sb.push_back(d_beat(AccessAckData, 3'd2, 1'(k), 1'b0, 1'b0, 32'h0000_0200 + 32'(k)));
            tick();
        end
        dev_d_valid = '0;
        #1;
        check("limit_drained_idle", 64'(idle_o), 64'd1);

        // D arbitration: hold under back-pressure, then dev0, dev2, error in order.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        host_d_ready = 1'b0;
        drive_a(Get, 32'h0000_0000, 3'd2, 1'b0);
        tick();
        drive_a(Get, 32'h2000_0000, 3'd2, 1'b1);
        tick();
        drive_a(PutFullData, 32'hDEAD_0000, 3'd2, 1'b0);
        tick();
        host_a_valid = 1'b0;
        dev_resp(0, AccessAckData, 3'd2, 1'b0, 32'hD0D0_0000);
        dev_resp(2, AccessAckData, 3'd2, 1'b1, 32'hD2D2_0000);
        sb.push_back(d_beat(AccessAckData, 3'd2, 1'b0, 1'b0, 1'b0, 32'hD0D0_0000));
        sb.push_back(d_beat(AccessAckData, 3'd2, 1'b1, 1'b0, 1'b0, 32'hD2D2_0000));
        sb.push_back(d_beat(AccessAck, 3'd2, 1'b0, 1'b1, 1'b0, 32'd0));
        for (int k = 0; k < 3; k++) begin
            #1;
            check("arb_hold_data", 64'(host_d_data), 64'hD0D0_0000);
            check("arb_hold_dready", 64'(dev_d_ready), 64'd0);
            tick();
        end
        host_d_ready = 1'b1;
        tick();
        dev_d_valid[0] = 1'b0;
        tick();
        dev_d_valid[2] = 1'b0;
        tick();
        check("arb_done_idle", 64'(idle_o), 64'd1);
        check("arb_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with two requests in flight and a response pending.
        drive_a(Get, 32'h1000_0000, 3'd2, 1'b0);
        tick();
        drive_a(Get, 32'h2000_0000, 3'd2, 1'b1);
        tick();
        host_a_valid = 1'b0;
        host_d_ready = 1'b0;
        dev_resp(1, AccessAckData, 3'd2, 1'b0, 32'h1111_0000);
        #1;
        check("rst_mid_busy", 64'(idle_o), 64'd0);
        rst_i = 1'b1;
        #1;
        check("rst_mid_idle", 64'(idle_o), 64'd1);
        check("rst_mid_dvalid", 64'(host_d_valid), 64'd0);
        dev_d_valid = '0;
        host_d_ready = 1'b1;
        tick();
        rst_i = 1'b0;
        drive_a(Get, 32'h3000_0008, 3'd2, 1'b1);
        #1;
        check("rst_after_fwd", 64'(dev_a_valid), 64'b1000);
        tick();
        host_a_valid = 1'b0;
        dev_resp(3, AccessAckData, 3'd2, 1'b1, 32'h3333_0000);
        sb.push_back(d_beat(AccessAckData, 3'd2, 1'b1, 1'b0, 1'b0, 32'h3333_0000));
        tick();
        dev_d_valid = '0;
        #1;
        check("rst_after_idle", 64'(idle_o), 64'd1);

        // Simultaneous A and D fire on dev3 at count 2 keeps the count at 2.
        drive_a(Get, 32'h3000_0000, 3'd2, 1'b0);
        tick();
        tick();
        dev_resp(3, AccessAckData, 3'd2, 1'b0, 32'h4444_0000);
        sb.push_back(d_beat(AccessAckData, 3'd2, 1'b0, 1'b0, 1'b0, 32'h4444_0000));
        #1;
        check("simul_a_ready", 64'(host_a_ready), 64'd1);
        check("simul_d_ready", 64'(dev_d_ready), 64'b1000);
        tick();
        host_a_valid = 1'b0;
        dev_d_valid = '0;
        #1;
        check("simul_busy", 64'(idle_o), 64'd0);
        dev_resp(3, AccessAckData, 3'd2, 1'b0, 32'h5555_0000);
        sb.push_back(d_beat(AccessAckData, 3'd2, 1'b0, 1'b0, 1'b0, 32'h5555_0000));
        tick();
        dev_d_valid = '0;
        #1;
        check("simul_one_left", 64'(idle_o), 64'd0);
        dev_resp(3, AccessAckData, 3'd2, 1'b0, 32'h6666_0000);
        sb.push_back(d_beat(AccessAckData, 3'd2, 1'b0, 1'b0, 1'b0, 32'h6666_0000));
        tick();
        dev_d_valid = '0;
        #1;
        check("simul_drained", 64'(idle_o), 64'd1);

        // Oversized Get to a mapped address goes to the error responder.
        drive_a(Get, 32'h1000_0000, 3'd3, 1'b1);
        #1;
        check("oversize_no_dev", 64'(dev_a_valid), 64'd0);
        check("oversize_accept", 64'(host_a_ready), 64'd1);
        sb.push_back(d_beat(AccessAckData, 3'd3, 1'b1, 1'b1, 1'b1, 32'd0));
        tick();
        host_a_valid = 1'b0;
        tick();
        check("oversize_idle", 64'(idle_o), 64'd1);

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
